// File: rtl/al_bky_load_seq.sv
// al_bky_load_seq
//   Sequencer for the automatic Buckeye load path (CLK40 domain). A START
//   resets the slow-control FIFO, fetches NWORDS 16-bit configuration words
//   from the BPI read-back port, strobes each into the Buckeye loader with
//   CAPTURE, then waits for AL_DONE, clears it and reports status.
//
// Ports
//   CLK40         in   40 MHz clock
//   RST           in   asynchronous active-high reset
//   START         in   one-cycle start request (honoured only when idle)
//   ABORT         in   one-cycle abort request (ignored when idle)
//   BPI_RD_REQ    out  one-cycle word request to the BPI controller
//   BPI_DATA      in   read-back word, qualified by BPI_DVALID
//   BPI_DVALID    in   one-cycle data-valid strobe
//   BPI_AL_REG    out  word presented to the loader FIFO
//   CAPTURE       out  one-cycle FIFO write / loader start
//   SLOW_FIFO_RST out  loader FIFO reset
//   AL_DONE       in   loader finished (level)
//   CLR_AL_DONE   out  one-cycle clear of AL_DONE
//   BUSY          out  high whenever the sequencer is not idle
//   SEQ_DONE      out  sticky end-of-sequence flag, cleared by next START
//   ERR           out  00 ok, 01 data timeout, 10 done timeout, 11 aborted
//   WORD_CNT      out  words captured in the current/last sequence
//
// Every output is a register updated on the edge that leaves the state
// generating it, so a strobe belonging to state X is visible in the cycle
// after X. SLOW_FIFO_RST is the exception: it rises on the START edge.

module al_bky_load_seq #(
    parameter int NWORDS    = 54,
    parameter int FRST_CYC  = 8,
    parameter int FRST_WAIT = 32,
    parameter int DATA_TO   = 255,
    parameter int DONE_TO   = 1000000
) (
    input  logic        CLK40,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    output logic        BPI_RD_REQ,
    input  logic [15:0] BPI_DATA,
    input  logic        BPI_DVALID,
    output logic [15:0] BPI_AL_REG,
    output logic        CAPTURE,
    output logic        SLOW_FIFO_RST,
    input  logic        AL_DONE,
    output logic        CLR_AL_DONE,
    output logic        BUSY,
    output logic        SEQ_DONE,
    output logic [1:0]  ERR,
    output logic [8:0]  WORD_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRST,
        S_FSETTLE,
        S_REQ,
        S_WAIT_D,
        S_CAPT,
        S_WAIT_AD,
        S_CLR
    } state_t;

    localparam logic [15:0] L_FRST_LAST   = 16'(FRST_CYC - 1);
    localparam logic [15:0] L_SETTLE_LAST = 16'(FRST_WAIT - 1);
    localparam logic [7:0]  L_DATA_TO     = 8'(DATA_TO);
    localparam logic [23:0] L_DONE_LAST   = 24'(DONE_TO - 1);
    localparam logic [8:0]  L_NWORDS      = 9'(NWORDS);

    state_t      r_state;
    logic [15:0] r_cnt;      // FRST / FSETTLE cycle counter
    logic [7:0]  r_dtmr;     // cycles left before data timeout
    logic [23:0] r_dntmr;    // cycles spent in WAIT_AD (saturating)
    logic [8:0]  w_wcnt_nxt;

    assign w_wcnt_nxt = WORD_CNT + 9'd1;

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_dtmr        <= '0;
            r_dntmr       <= '0;
            BPI_RD_REQ    <= 1'b0;
            BPI_AL_REG    <= 16'h0000;
            CAPTURE       <= 1'b0;
            SLOW_FIFO_RST <= 1'b0;
            CLR_AL_DONE   <= 1'b0;
            BUSY          <= 1'b0;
            SEQ_DONE      <= 1'b0;
            ERR           <= 2'b00;
            WORD_CNT      <= '0;
        end else begin
            // single-cycle strobes default low
            BPI_RD_REQ  <= 1'b0;
            CAPTURE     <= 1'b0;
            CLR_AL_DONE <= 1'b0;

            // ABORT takes priority over every timeout. CLR is already on its
            // way out, so an abort there would only overwrite a valid status.
            if (ABORT && r_state != S_IDLE && r_state != S_CLR) begin
                r_state       <= S_CLR;
                ERR           <= 2'b11;
                SLOW_FIFO_RST <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (START) begin
                            r_state       <= S_FRST;
                            r_cnt         <= '0;
                            SLOW_FIFO_RST <= 1'b1;
                            BUSY          <= 1'b1;
                            SEQ_DONE      <= 1'b0;
                            ERR           <= 2'b00;
                            WORD_CNT      <= '0;
                        end
                    end
                    S_FRST: begin
                        if (r_cnt == L_FRST_LAST) begin
                            r_state       <= S_FSETTLE;
                            r_cnt         <= '0;
                            SLOW_FIFO_RST <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_FSETTLE: begin
                        if (r_cnt == L_SETTLE_LAST) begin
                            r_state <= S_REQ;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_REQ: begin
                        BPI_RD_REQ <= 1'b1;
                        r_dtmr     <= L_DATA_TO;
                        r_state    <= S_WAIT_D;
                    end
                    S_WAIT_D: begin
                        // data on the last allowed cycle still wins
                        if (BPI_DVALID) begin
                            BPI_AL_REG <= BPI_DATA;
                            r_state    <= S_CAPT;
                        end else if (r_dtmr == 8'd0) begin
                            ERR     <= 2'b01;
                            r_state <= S_CLR;
                        end else begin
                            r_dtmr <= r_dtmr - 8'd1;
                        end
                    end
                    S_CAPT: begin
                        CAPTURE  <= 1'b1;
                        WORD_CNT <= w_wcnt_nxt;
                        if (w_wcnt_nxt == L_NWORDS) begin
                            r_dntmr <= '0;
                            r_state <= S_WAIT_AD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                    S_WAIT_AD: begin
                        if (AL_DONE) begin
                            r_state <= S_CLR;
                        end else if (r_dntmr == L_DONE_LAST) begin
                            ERR     <= 2'b10;
                            r_state <= S_CLR;
                        end else if (r_dntmr != '1) begin
                            r_dntmr <= r_dntmr + 24'd1;
                        end
                    end
                    S_CLR: begin
                        CLR_AL_DONE <= 1'b1;
                        SEQ_DONE    <= 1'b1;
                        BUSY        <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_al_bky_load_seq.sv
// Bench for al_bky_load_seq: table of whole-sequence scenarios plus hand
// sequences for idle behaviour and asynchronous reset. A BPI model answers
// read requests and pushes each word it sends onto a scoreboard queue; every
// CAPTURE pops and checks data and DVALID-to-CAPTURE latency.

module tb_al_bky_load_seq;

    localparam int NW   = 4;
    localparam int FRC  = 8;
    localparam int FRW  = 32;
    localparam int DTO  = 20;
    localparam int DNTO = 100;

    logic        CLK40, RST, START, ABORT, BPI_DVALID, AL_DONE;
    logic [15:0] BPI_DATA;
    logic        BPI_RD_REQ, CAPTURE, SLOW_FIFO_RST, CLR_AL_DONE, BUSY, SEQ_DONE;
    logic [15:0] BPI_AL_REG;
    logic [1:0]  ERR;
    logic [8:0]  WORD_CNT;

    al_bky_load_seq #(
        .NWORDS(NW), .FRST_CYC(FRC), .FRST_WAIT(FRW), .DATA_TO(DTO), .DONE_TO(DNTO)
    ) dut (
        .CLK40(CLK40), .RST(RST), .START(START), .ABORT(ABORT),
        .BPI_RD_REQ(BPI_RD_REQ), .BPI_DATA(BPI_DATA), .BPI_DVALID(BPI_DVALID),
        .BPI_AL_REG(BPI_AL_REG), .CAPTURE(CAPTURE), .SLOW_FIFO_RST(SLOW_FIFO_RST),
        .AL_DONE(AL_DONE), .CLR_AL_DONE(CLR_AL_DONE), .BUSY(BUSY),
        .SEQ_DONE(SEQ_DONE), .ERR(ERR), .WORD_CNT(WORD_CNT)
    );

    initial begin
        CLK40 = 1'b0;
        forever #5 CLK40 = ~CLK40;
    end

    int cyc = 0;
    always @(posedge CLK40) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- BPI model + output monitor ----------------
    typedef struct { logic [15:0] d; int c; } sb_t;
    sb_t sb[$];

    int bpi_lat = 3, bpi_silent = -1, bpi_base = 0;   // written by main
    int inj_cnt = 0;                                   // written by main
    int n_req = 0, inj_seen = 0, pend = 0;
    logic [15:0] pend_d = '0;
    int n_capt = 0, n_clr = 0, n_frst_rise = 0, frst_hi = 0;
    int frst_rise_cyc = -1, first_rdreq_cyc = -1, last_rdreq_cyc = -1;
    int last_capt_cyc = -1, clr_cyc = -1, err_cyc = -1;
    logic frst_q = 1'b0;

    initial begin
        sb_t ent;
        int  idx;
        BPI_DVALID = 1'b0;
        BPI_DATA   = '0;
        forever begin
            @(posedge CLK40); #1;
            BPI_DVALID = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    BPI_DVALID = 1'b1;
                    BPI_DATA   = pend_d;
                    ent.d = pend_d;
                    ent.c = cyc;
                    sb.push_back(ent);
                end
            end
            if (inj_cnt != inj_seen) begin
                inj_seen   = inj_cnt;
                BPI_DVALID = 1'b1;
                BPI_DATA   = 16'hDEAD;
            end
            if (BPI_RD_REQ) begin
                idx = n_req - bpi_base;
                n_req++;
                if (idx != bpi_silent) begin
                    pend   = bpi_lat;
                    pend_d = 16'hA5A0 + 16'(idx);
                end
            end
            @(negedge CLK40);
            if (SLOW_FIFO_RST && !frst_q) begin
                n_frst_rise++;
                frst_rise_cyc   = cyc;
                frst_hi         = 0;
                first_rdreq_cyc = -1;
                err_cyc         = -1;
            end
            if (SLOW_FIFO_RST) frst_hi++;
            frst_q = SLOW_FIFO_RST;
            if (BPI_RD_REQ) begin
                if (first_rdreq_cyc < 0) first_rdreq_cyc = cyc;
                last_rdreq_cyc = cyc;
            end
            if (ERR != 2'b00 && err_cyc < 0) err_cyc = cyc;
            if (CLR_AL_DONE) begin
                n_clr++;
                clr_cyc = cyc;
            end
            if (CAPTURE) begin
                n_capt++;
                last_capt_cyc = cyc;
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ent = sb.pop_front();
                    check("capt_data", BPI_AL_REG, ent.d);
                    check("dv_to_capt", cyc - ent.c, 2);
                end
            end
        end
    end

    // ---------------- scenario table ----------------
    typedef struct {
        string nm;
        int    lat;        // BPI response latency after BPI_RD_REQ
        int    silent;     // word index BPI never answers (-1 none)
        int    done_dly;   // AL_DONE this many cycles after last CAPTURE (-1 never)
        bit    al_pre;     // AL_DONE already high from START
        int    abort_after;// ABORT one cycle after this CAPTURE (0 none)
        bit    abort_to;   // ABORT in the cycle the done timeout fires
        bit    start_mid;  // extra START after the first CAPTURE
        int    err;
        int    wcnt;
    } vec_t;

    function automatic vec_t mk(string nm, int lat, int sil, int dd, bit pre,
                                int aa, bit ato, bit smid, int err, int wc);
        vec_t v;
        v.nm = nm; v.lat = lat; v.silent = sil; v.done_dly = dd; v.al_pre = pre;
        v.abort_after = aa; v.abort_to = ato; v.start_mid = smid;
        v.err = err; v.wcnt = wc;
        return v;
    endfunction

    vec_t vt[8];

    task automatic tick();
        @(posedge CLK40); #1;
    endtask

    task automatic check_zero(input string p);
        check({p, ".rd_req"}, BPI_RD_REQ, 0);
        check({p, ".al_reg"}, BPI_AL_REG, 0);
        check({p, ".capture"}, CAPTURE, 0);
        check({p, ".fifo_rst"}, SLOW_FIFO_RST, 0);
        check({p, ".clr"}, CLR_AL_DONE, 0);
        check({p, ".busy"}, BUSY, 0);
        check({p, ".seq_done"}, SEQ_DONE, 0);
        check({p, ".err"}, ERR, 0);
        check({p, ".wcnt"}, WORD_CNT, 0);
    endtask

    task automatic run_seq(input vec_t v);
        int cb, kb, fb, s_cyc, al_cyc, ab_cyc;
        bit done, st_done;
        cb = n_capt; kb = n_clr; fb = n_frst_rise;
        bpi_lat = v.lat; bpi_silent = v.silent; bpi_base = n_req;
        AL_DONE = v.al_pre;
        al_cyc = -1; ab_cyc = -1; done = 0; st_done = 0;
        START = 1'b1;
        s_cyc = cyc;
        tick();
        START = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            ABORT = 1'b0;
            START = 1'b0;
            if (SEQ_DONE) begin
                done = 1;
            end else begin
                if (v.start_mid && !st_done && n_capt - cb == 1) begin
                    START = 1'b1;
                    st_done = 1;
                end
                if (v.abort_after > 0 && ab_cyc < 0 && n_capt - cb == v.abort_after) begin
                    ABORT = 1'b1;
                    ab_cyc = cyc;
                end
                // WAIT_AD starts in the last CAPTURE cycle; the done timeout
                // fires on the edge ending cycle last_capt+DONE_TO-1
                if (v.abort_to && ab_cyc < 0 && n_capt - cb == NW &&
                    cyc == last_capt_cyc + DNTO - 1) begin
                    ABORT = 1'b1;
                    ab_cyc = cyc;
                end
                if (v.done_dly >= 0 && al_cyc < 0 && n_capt - cb == NW &&
                    cyc == last_capt_cyc + v.done_dly) begin
                    AL_DONE = 1'b1;
                    al_cyc = cyc;
                end
                tick();
            end
        end
        AL_DONE = 1'b0;
        ABORT   = 1'b0;
        START   = 1'b0;
        tick();
        check({v.nm, ".finished"}, done, 1);
        check({v.nm, ".err"}, ERR, v.err);
        check({v.nm, ".wcnt"}, WORD_CNT, v.wcnt);
        check({v.nm, ".busy"}, BUSY, 0);
        check({v.nm, ".seq_done"}, SEQ_DONE, 1);
        check({v.nm, ".clr_pulse_ended"}, CLR_AL_DONE, 0);
        check({v.nm, ".n_capture"}, n_capt - cb, v.wcnt);
        check({v.nm, ".n_clr"}, n_clr - kb, 1);
        check({v.nm, ".n_fifo_rst"}, n_frst_rise - fb, 1);
        check({v.nm, ".fifo_rst_width"}, frst_hi, FRC);
        check({v.nm, ".start_to_frst"}, frst_rise_cyc - s_cyc, 1);
        check({v.nm, ".frst_to_req"}, first_rdreq_cyc - frst_rise_cyc, FRC + FRW + 1);
        check({v.nm, ".sb_drained"}, sb.size(), 0);
        if (v.al_pre)     check({v.nm, ".capt_to_clr"}, clr_cyc - last_capt_cyc, 2);
        if (al_cyc >= 0)  check({v.nm, ".aldone_to_clr"}, clr_cyc - al_cyc, 2);
        if (ab_cyc >= 0)  check({v.nm, ".abort_to_clr"}, clr_cyc - ab_cyc, 2);
        if (v.err == 1)   check({v.nm, ".data_to_time"}, err_cyc - last_rdreq_cyc, DTO + 1);
        if (v.err == 2)   check({v.nm, ".done_to_time"}, err_cyc - last_capt_cyc, DNTO);
        if (v.abort_to)   check({v.nm, ".err_time"}, err_cyc - last_capt_cyc, DNTO);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cb, kb;
        bit  ok;
        //        name          lat sil  dd pre ab ato smid err wc
        vt[0] = mk("nominal",    3, -1, 50, 0,  0, 0,  0,   0, 4);
        vt[1] = mk("fast_bpi",   1, -1,  1, 0,  0, 0,  0,   0, 4);
        vt[2] = mk("aldone_pre", 2, -1, -1, 1,  0, 0,  0,   0, 4);
        vt[3] = mk("data_to",    3,  2, -1, 0,  0, 0,  0,   1, 2);
        vt[4] = mk("dv_at_to", DTO, -1,  5, 0,  0, 0,  0,   0, 4);
        vt[5] = mk("done_to",    2, -1, -1, 0,  0, 0,  0,   2, 4);
        vt[6] = mk("abort",      3,  2, -1, 0,  2, 0,  1,   3, 2);
        vt[7] = mk("abort_at_to",1, -1, -1, 0,  0, 1,  0,   3, 4);

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; AL_DONE = 1'b0;
        repeat (3) tick();
        check_zero("in_reset");
        RST = 1'b0;
        tick();
        check_zero("after_reset");

        // DVALID and ABORT while idle must be ignored
        inj_cnt++;
        repeat (3) tick();
        check("idle.dv_reg", BPI_AL_REG, 0);
        check("idle.dv_busy", BUSY, 0);
        kb = n_clr;
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        repeat (3) tick();
        check("idle.abort_seq_done", SEQ_DONE, 0);
        check("idle.abort_err", ERR, 0);
        check("idle.abort_clr", n_clr - kb, 0);

        for (int i = 0; i < 8; i++) run_seq(vt[i]);

        // asynchronous reset while waiting on the second word
        bpi_lat = 2; bpi_silent = 1; bpi_base = n_req;
        cb = n_capt;
        START = 1'b1;
        tick();
        START = 1'b0;
        ok = 0;
        for (int k = 0; k < 500 && !ok; k++) begin
            if (n_capt - cb == 1 && last_rdreq_cyc > last_capt_cyc &&
                cyc >= last_rdreq_cyc + 5) ok = 1;
            else tick();
        end
        check("rst.reach_wait_d", ok, 1);
        check("rst.pre_busy", BUSY, 1);
        check("rst.pre_wcnt", WORD_CNT, 1);
        check("rst.pre_reg", BPI_AL_REG, 16'hA5A0);
        #2 RST = 1'b1;
        #1 check_zero("rst_async");
        tick();
        RST = 1'b0;
        tick();
        check("rst.sb_empty", sb.size(), 0);
        run_seq(vt[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
